// File: rtl/bg_mean_calc.sv
// Background-colour mean: accumulates per-PE RGB sums, then divides each channel by the pixel count.
// The three channels share one restoring-divider sequence; the results are held behind a Done/Ack handshake.
//
//   state | meaning
//   IDLE  | waiting for Start; the previous results are still shown
//   ACC   | adding one PE's sum triple on each sum_valid beat
//   DIV   | ACC_W restoring steps (1 cycle if the count is zero)
//   DONE  | results valid; waiting for Ack
module bg_mean_calc #(
  parameter int NUM_PE = 4,
  parameter int SUM_W  = 17,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = SUM_W + $clog2(NUM_PE)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             sum_valid,
  input  logic [SUM_W-1:0] red_sum_in,
  input  logic [SUM_W-1:0] green_sum_in,
  input  logic [SUM_W-1:0] blue_sum_in,
  input  logic [CNT_W-1:0] pixel_count,
  input  logic             Ack,
  output logic [8:0]       red_exp,
  output logic [8:0]       green_exp,
  output logic [8:0]       blue_exp,
  output logic             div0,
  output logic             Done,
  output logic             Qi,
  output logic             Qacc,
  output logic             Qdiv,
  output logic             Qd
);

  localparam int BW = $clog2(NUM_PE + 1);
  localparam int DW = $clog2(ACC_W + 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_ACC  = 4'b0010,
    S_DIV  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_r_q, acc_g_q, acc_b_q;
  logic [ACC_W-1:0] acc_r_d, acc_g_d, acc_b_d;
  logic [CNT_W:0]   rem_r_q, rem_g_q, rem_b_q;
  logic [CNT_W:0]   rem_r_d, rem_g_d, rem_b_d;
  logic [BW-1:0]    beat_q;
  logic [DW-1:0]    div_cnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic [8:0]       red_q, green_q, blue_q;
  logic             div0_q;

  // One restoring step. The accumulator doubles as the dividend shift register:
  // dividend bits leave at the MSB while quotient bits enter at the LSB.
  // The remainder always stays below the divisor, so its top bit is never needed before the shift.
  function automatic logic [CNT_W+ACC_W:0] div_step(input logic [CNT_W:0]   rem,
                                                     input logic [ACC_W-1:0] dq,
                                                     input logic [CNT_W-1:0] dvs);
    logic [CNT_W:0] sh;
    sh = {rem[CNT_W-1:0], dq[ACC_W-1]};
    if (sh >= {1'b0, dvs}) return {sh - {1'b0, dvs}, dq[ACC_W-2:0], 1'b1};
    else                   return {sh, dq[ACC_W-2:0], 1'b0};
  endfunction

  function automatic logic [8:0] sat8(input logic [ACC_W-1:0] q);
    return (|q[ACC_W-1:8]) ? 9'd255 : {1'b0, q[7:0]};
  endfunction

  always_comb begin
    {rem_r_d, acc_r_d} = div_step(rem_r_q, acc_r_q, cnt_q);
    {rem_g_d, acc_g_d} = div_step(rem_g_q, acc_g_q, cnt_q);
    {rem_b_d, acc_b_d} = div_step(rem_b_q, acc_b_q, cnt_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      acc_r_q   <= '0;
      acc_g_q   <= '0;
      acc_b_q   <= '0;
      rem_r_q   <= '0;
      rem_g_q   <= '0;
      rem_b_q   <= '0;
      beat_q    <= '0;
      div_cnt_q <= '0;
      cnt_q     <= '0;
      red_q     <= '0;
      green_q   <= '0;
      blue_q    <= '0;
      div0_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (Start) begin
          state_q <= S_ACC;
          acc_r_q <= '0;
          acc_g_q <= '0;
          acc_b_q <= '0;
          beat_q  <= '0;
          cnt_q   <= pixel_count;
        end
        S_ACC: if (sum_valid) begin
          acc_r_q <= acc_r_q + ACC_W'(red_sum_in);
          acc_g_q <= acc_g_q + ACC_W'(green_sum_in);
          acc_b_q <= acc_b_q + ACC_W'(blue_sum_in);
          beat_q  <= beat_q + 1'b1;
          if (beat_q == BW'(NUM_PE - 1)) begin
            state_q   <= S_DIV;
            rem_r_q   <= '0;
            rem_g_q   <= '0;
            rem_b_q   <= '0;
            div_cnt_q <= '0;
          end
        end
        S_DIV: if (cnt_q == '0) begin
          red_q   <= '0;
          green_q <= '0;
          blue_q  <= '0;
          div0_q  <= 1'b1;
          state_q <= S_DONE;
        end else begin
          acc_r_q   <= acc_r_d;
          acc_g_q   <= acc_g_d;
          acc_b_q   <= acc_b_d;
          rem_r_q   <= rem_r_d;
          rem_g_q   <= rem_g_d;
          rem_b_q   <= rem_b_d;
          div_cnt_q <= div_cnt_q + 1'b1;
          if (div_cnt_q == DW'(ACC_W - 1)) begin
            red_q   <= sat8(acc_r_d);
            green_q <= sat8(acc_g_d);
            blue_q  <= sat8(acc_b_d);
            div0_q  <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_DONE: if (Ack) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign {Qd, Qdiv, Qacc, Qi} = state_q;
  assign Done      = state_q[3];
  assign red_exp   = red_q;
  assign green_exp = green_q;
  assign blue_exp  = blue_q;
  assign div0      = div0_q;

endmodule

// File: tb/tb_bg_mean_calc.sv
// Scoreboard bench for bg_mean_calc: the stimulus process pushes model results, and a monitor checks each Done.
module tb_bg_mean_calc;
  localparam int NUM_PE = 4;
  localparam int SUM_W  = 17;
  localparam int CNT_W  = 16;
  localparam int ACC_W  = 19;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             Start = 1'b0;
  logic             sum_valid = 1'b0;
  logic [SUM_W-1:0] red_sum_in = '0, green_sum_in = '0, blue_sum_in = '0;
  logic [CNT_W-1:0] pixel_count = '0;
  logic             Ack = 1'b0;
  logic [8:0]       red_exp, green_exp, blue_exp;
  logic             div0, Done, Qi, Qacc, Qdiv, Qd;

  bg_mean_calc #(.NUM_PE(NUM_PE), .SUM_W(SUM_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .sum_valid(sum_valid),
    .red_sum_in(red_sum_in), .green_sum_in(green_sum_in), .blue_sum_in(blue_sum_in),
    .pixel_count(pixel_count), .Ack(Ack), .red_exp(red_exp), .green_exp(green_exp),
    .blue_exp(blue_exp), .div0(div0), .Done(Done), .Qi(Qi), .Qacc(Qacc), .Qdiv(Qdiv), .Qd(Qd)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int r; int g; int b; bit d0; int lat; int sc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int br[NUM_PE], bgr[NUM_PE], bb[NUM_PE], gp[NUM_PE];

  function automatic void chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endfunction

  function automatic int mean_sat(input longint tot, input int cnt);
    longint q;
    if (cnt == 0) return 0;
    q = tot / cnt;
    return (q > 255) ? 255 : int'(q);
  endfunction

  // Monitor: checks the flag invariants every cycle and output holding during a run, and pops one expectation per Done.
  initial begin : monitor
    bit done_prev = 1'b0;
    int hr = 0, hg = 0, hb = 0;
    bit hd = 1'b0;
    exp_t e;
    forever begin
      @(negedge Clk);
      chk("onehot", $onehot({Qd, Qdiv, Qacc, Qi}), 1);
      chk("done_eq_qd", Done, Qd);
      if (!Reset_n) begin
        hr = 0; hg = 0; hb = 0; hd = 1'b0;
      end
      if (Qacc || Qdiv) begin
        chk("hold_red", red_exp, hr);
        chk("hold_green", green_exp, hg);
        chk("hold_blue", blue_exp, hb);
        chk("hold_div0", div0, hd);
      end
      if (Done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("red_exp", red_exp, e.r);
          chk("green_exp", green_exp, e.g);
          chk("blue_exp", blue_exp, e.b);
          chk("div0", div0, e.d0);
          chk("latency", cyc - e.sc, e.lat);
          hr = e.r; hg = e.g; hb = e.b; hd = e.d0;
        end
      end
      done_prev = Done;
    end
  end

  task automatic drive_beats();
    for (int i = 0; i < NUM_PE; i++) begin
      for (int k = 0; k < gp[i]; k++) begin
        sum_valid = 1'b0;
        @(posedge Clk); #1;
      end
      sum_valid    = 1'b1;
      red_sum_in   = SUM_W'(br[i]);
      green_sum_in = SUM_W'(bgr[i]);
      blue_sum_in  = SUM_W'(bb[i]);
      @(posedge Clk); #1;
      sum_valid    = 1'b0;
      red_sum_in   = SUM_W'($urandom);
      green_sum_in = SUM_W'($urandom);
      blue_sum_in  = SUM_W'($urandom);
    end
  endtask

  task automatic run_job(input int cnt, input bit hold_ack, input bit ack_with_start);
    exp_t e;
    longint tr = 0, tg = 0, tb = 0;
    int accc = NUM_PE;
    int w = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      tr += br[i]; tg += bgr[i]; tb += bb[i]; accc += gp[i];
    end
    e.r   = mean_sat(tr, cnt);
    e.g   = mean_sat(tg, cnt);
    e.b   = mean_sat(tb, cnt);
    e.d0  = (cnt == 0);
    e.lat = 1 + accc + ((cnt == 0) ? 1 : ACC_W);
    @(posedge Clk); #1;
    Start = 1'b1;
    pixel_count = CNT_W'(cnt);
    Ack = hold_ack;
    e.sc = cyc;
    exp_q.push_back(e);
    @(posedge Clk); #1;
    Start = 1'b0;
    pixel_count = CNT_W'($urandom);
    drive_beats();
    while (!Done && w < 200) begin
      @(posedge Clk); #1;
      w++;
    end
    if (!Done) chk("done_timeout", 0, 1);
    Ack = 1'b1;
    Start = ack_with_start;
    @(posedge Clk); #1;
    Ack = 1'b0;
    Start = 1'b0;
    if (ack_with_start) begin
      chk("ack_start_qi", Qi, 1);
      chk("ack_start_red", red_exp, e.r);
      chk("ack_start_green", green_exp, e.g);
      chk("ack_start_blue", blue_exp, e.b);
      @(posedge Clk); #1;
      chk("start_in_done_ignored", Qi, 1);
    end
  endtask

  task automatic set_beats(input int r0, input int r1, input int r2, input int r3,
                           input int g0, input int g1, input int g2, input int g3,
                           input int b0, input int b1, input int b2, input int b3, input int gap);
    br[0] = r0; br[1] = r1; br[2] = r2; br[3] = r3;
    bgr[0] = g0; bgr[1] = g1; bgr[2] = g2; bgr[3] = g3;
    bb[0] = b0; bb[1] = b1; bb[2] = b2; bb[3] = b3;
    gp[0] = 0; gp[1] = gap; gp[2] = gap; gp[3] = gap;
  endtask

  initial begin : stim
    int cnt;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_qi", Qi, 1);
    chk("rst_red", red_exp, 0);
    chk("rst_green", green_exp, 0);
    chk("rst_blue", blue_exp, 0);
    chk("rst_div0", div0, 0);
    chk("rst_done", Done, 0);
    Reset_n = 1'b1;

    set_beats(100, 200, 300, 400, 10, 20, 30, 40, 0, 0, 0, 0, 0);
    run_job(10, 1'b0, 1'b0);
    set_beats(100, 200, 300, 400, 10, 20, 30, 40, 0, 0, 0, 0, 3);
    run_job(10, 1'b0, 1'b0);
    set_beats(250, 250, 250, 250, 127, 128, 128, 128, 1, 1, 1, 2, 0);
    run_job(2, 1'b0, 1'b0);
    set_beats(5000, 7, 99, 1, 3, 3, 3, 3, 131071, 0, 0, 1, 1);
    run_job(0, 1'b0, 1'b0);
    set_beats(1000, 2000, 3000, 4000, 40, 40, 40, 40, 80, 80, 80, 80, 2);
    run_job(100, 1'b1, 1'b1);

    // Abandon a run partway through its divide with an asynchronous reset.
    set_beats(131071, 131071, 131071, 131071, 5, 5, 5, 5, 9, 9, 9, 9, 0);
    @(posedge Clk); #1;
    Start = 1'b1;
    pixel_count = 16'd3;
    @(posedge Clk); #1;
    Start = 1'b0;
    drive_beats();
    repeat (5) @(posedge Clk);
    #1;
    chk("pre_rst_in_div", Qdiv, 1);
    Reset_n = 1'b0;
    #1;
    chk("midrst_qi", Qi, 1);
    chk("midrst_red", red_exp, 0);
    chk("midrst_green", green_exp, 0);
    chk("midrst_blue", blue_exp, 0);
    chk("midrst_div0", div0, 0);
    chk("midrst_done", Done, 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    set_beats(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_job(1, 1'b0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NUM_PE; i++) begin
        br[i]  = int'($urandom_range(0, 131071));
        bgr[i] = int'($urandom_range(0, 131071));
        bb[i]  = int'($urandom_range(0, 131071));
        gp[i]  = int'($urandom_range(0, 2));
      end
      case ($urandom_range(0, 3))
        0:       cnt = int'($urandom_range(0, 3));
        1:       cnt = int'($urandom_range(256, 4096));
        default: cnt = int'($urandom_range(0, 65535));
      endcase
      run_job(cnt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge Clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bg_mean_calc.md
Name: bg_mean_calc

Overview:
Computes the expected background colour (red_exp, green_exp, blue_exp) that feeds the pe background-removal stage.
It consumes the per-PE red/green/blue sums produced by the SUM phase of each pe, one PE per beat, and accumulates them.
It then divides each channel total by the total pixel count with a sequential restoring divider.
It presents the 9-bit means with a Done/Ack handshake, sitting between the array's SUM phase and its BG phase.

Parameters:
NUM_PE, 4, number of pe sum triples accumulated per run (>=1)
SUM_W, 17, width of each incoming per-PE channel sum
CNT_W, 16, width of total pixel count
ACC_W, SUM_W+$clog2(NUM_PE) (default 19), accumulator/dividend width; also divide latency in cycles

Ports:
Clk  input  1  clock; all state changes on rising edge
Reset_n  input  1  asynchronous, active-low reset
Start  input  1  begin a run; sampled only in IDLE
sum_valid  input  1  red/green/blue_sum_in carry one PE's sums this cycle
red_sum_in  input  SUM_W  one PE's red sum
green_sum_in  input  SUM_W  one PE's green sum
blue_sum_in  input  SUM_W  one PE's blue sum
pixel_count  input  CNT_W  total pixels over all PEs; sampled on the Start cycle
Ack  input  1  consumer accepted results; honoured only in DONE
red_exp  output  9  mean red, bit 8 always 0, saturated to 255
green_exp  output  9  mean green, same rules
blue_exp  output  9  mean blue, same rules
div0  output  1  last run had pixel_count==0
Done  output  1  results valid (equals Qd)
Qi, Qacc, Qdiv, Qd  output  1 each  one-hot state flags: IDLE, ACC, DIV, DONE

Behaviour:
- Reset (Reset_n=0, async):
  - state=IDLE; red/green/blue_exp=0; div0=0; accumulators, beat counter and divider registers=0.
  - Reset mid-run abandons the run with no partial update.
- State encoding is one-hot, 4 bits; {Qd,Qdiv,Qacc,Qi}=state; exactly one flag high at all times.
- IDLE:
  - Start=1 -> ACC next cycle; clear the three ACC_W accumulators and the beat counter; latch pixel_count.
  - Otherwise stay in IDLE. sum_valid ignored.
- ACC:
  - Each cycle with sum_valid=1: zero-extend each sum to ACC_W, add into its channel accumulator, increment the beat counter. Gaps (sum_valid=0) allowed; nothing changes on a gap.
  - On the beat that makes count==NUM_PE -> DIV next cycle; the accumulator includes that beat.
  - Start ignored.
- DIV:
  - If latched count==0: results forced to 0, div0=1, -> DONE after exactly 1 cycle.
  - Else three restoring dividers run in parallel, MSB first, one quotient bit per cycle for exactly ACC_W cycles. Remainder width CNT_W+1; no overflow possible.
  - Then -> DONE; div0=0.
  - Result per channel: quotient truncated (floor). If quotient>255, output 255; else quotient[7:0]. Bit 8 zero.
  - Outputs update only on the DIV->DONE transition; during ACC and DIV they hold the previous run's values.
- DONE:
  - Done=1; outputs stable.
  - Ack=1 -> IDLE next cycle, outputs keep their values. Ack=0 -> stay in DONE.
  - Ack in any other state ignored. Start in DONE ignored, even if simultaneous with Ack; a new Start must arrive in IDLE.
- Latency from Start edge to Done=1: 1 + (cycles of ACC until NUM_PE valid beats) + ACC_W. With back-to-back beats and defaults: 1 + 4 + 19 = 24 cycles.
- Accumulator overflow is impossible by construction: ACC_W bits hold NUM_PE × (2^SUM_W − 1).

Test Plan:
- Reset_n low mid-DIV (defaults) -> immediately Qi=1, all *_exp=0, div0=0, Done=0; a following Start with count 1 and all sums 0 completes normally with *_exp=0.
- Start, count=10, four back-to-back beats: red 100,200,300,400; green 10,20,30,40; blue 0 -> Done exactly 24 cycles after Start; red_exp=100, green_exp=10, blue_exp=0, div0=0.
- Same data as the 100/10/0 case with 3-cycle sum_valid gaps between beats -> identical results; Done asserted 9 cycles later than the back-to-back case.
- count=2, red sums total 1000, green total 511, blue total 5 -> red_exp=255 (saturated), green_exp=255, blue_exp=2 (floor of 2.5).
- count=0, any sums -> DONE one cycle after the last beat; all *_exp=0; div0=1.
- Ack held high during ACC/DIV -> no effect; in DONE, Ack together with Start -> IDLE, Start ignored, outputs retained; a later Start begins a new run normally.
